// File: rtl/button_event_scheduler.sv
// button_event_scheduler
//   Turns debounced per-button levels into a single stream of discrete events.
//   Each channel produces a press event on its rising edge, then auto-repeat
//   events while it is held. Every channel can queue one pending event. A
//   round-robin arbiter hands the pending events to one consumer over a
//   valid/ready handshake.
//
// Ports
//   clk              : clock; all state updates on the rising edge
//   rst              : asynchronous active-high reset
//   debounced_signal : [width] debounced button levels, synchronous to clk
//   event_valid      : an event is presented on event_index/event_repeat
//   event_index      : channel of the presented event
//   event_repeat     : 0 = press event, 1 = auto-repeat event
//   event_ready      : consumer accepts when event_valid && event_ready
//   pending          : [width] per-channel pending-event bits
//   event_dropped    : sticky; an event hit a channel that was already pending
module button_event_scheduler #(
  parameter int width         = 2,
  parameter int repeat_delay  = 50,
  parameter int repeat_period = 20,
  localparam int idx_w = (width > 1) ? $clog2(width) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] debounced_signal,
  output logic             event_valid,
  output logic [idx_w-1:0] event_index,
  output logic             event_repeat,
  input  logic             event_ready,
  output logic [width-1:0] pending,
  output logic             event_dropped
);

  localparam int max_cnt = (repeat_delay > repeat_period) ? repeat_delay : repeat_period;
  localparam int cnt_w   = $clog2(max_cnt + 1);
  localparam logic [cnt_w-1:0] delay_c  = cnt_w'(repeat_delay);
  localparam logic [cnt_w-1:0] period_c = cnt_w'(repeat_period);

  logic [width-1:0] prev_reg;
  logic [cnt_w-1:0] cnt_reg  [width];
  logic [cnt_w-1:0] cnt_next [width];
  logic [cnt_w-1:0] cnt_inc  [width];
  // Set once the first repeat has fired; selects delay vs. period threshold.
  logic [width-1:0] after_first_reg, after_first_next;
  logic [width-1:0] pending_reg, pending_next;
  logic [width-1:0] pend_rep_reg, pend_rep_next;
  logic [width-1:0] press, tick, clear, drop;

  logic             valid_reg;
  logic [idx_w-1:0] index_reg;
  logic             repeat_reg;
  logic [idx_w-1:0] last_grant_reg;
  logic             dropped_reg;

  logic [idx_w-1:0] grant;
  logic             load;

  // The output register can take a new event when it is empty or being emptied.
  assign load = (!valid_reg || event_ready) && (|pending_reg);

  // Round-robin search beginning just after the last granted channel.
  always_comb begin
    logic       found;
    int         s;
    logic [idx_w-1:0] cand;
    grant = last_grant_reg;
    found = 1'b0;
    s     = 0;
    cand  = '0;
    for (int k = 0; k < width; k++) begin
      s = int'(last_grant_reg) + 1 + k;
      if (s >= width) s = s - width;
      cand = idx_w'(s);
      if (!found && pending_reg[cand]) begin
        grant = cand;
        found = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < width; gi++) begin : g_ch
    assign press[gi]   = debounced_signal[gi] & ~prev_reg[gi];
    assign cnt_inc[gi] = cnt_reg[gi] + 1'b1;
    // A tick needs the button to have been high already, so it never
    // coincides with a press.
    assign tick[gi] = debounced_signal[gi] & prev_reg[gi] &
                      (cnt_inc[gi] == (after_first_reg[gi] ? period_c : delay_c));

    always_comb begin
      cnt_next[gi]         = cnt_inc[gi];
      after_first_next[gi] = after_first_reg[gi];
      if (!debounced_signal[gi] || press[gi]) begin
        cnt_next[gi]         = '0;
        after_first_next[gi] = 1'b0;
      end else if (tick[gi]) begin
        cnt_next[gi]         = '0;
        after_first_next[gi] = 1'b1;
      end
    end

    assign clear[gi] = load && (grant == idx_w'(gi));
    // A channel being loaded this cycle frees its slot, so a new event on it
    // re-arms the pending bit instead of being dropped.
    assign drop[gi]  = (press[gi] | tick[gi]) && pending_reg[gi] && !clear[gi];

    always_comb begin
      pending_next[gi]  = pending_reg[gi];
      pend_rep_next[gi] = pend_rep_reg[gi];
      if ((press[gi] | tick[gi]) && !drop[gi]) begin
        pending_next[gi]  = 1'b1;
        pend_rep_next[gi] = tick[gi];
      end else if (clear[gi]) begin
        pending_next[gi]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_reg        <= '0;
      after_first_reg <= '0;
      pending_reg     <= '0;
      pend_rep_reg    <= '0;
      for (int i = 0; i < width; i++) cnt_reg[i] <= '0;
    end else begin
      prev_reg        <= debounced_signal;
      after_first_reg <= after_first_next;
      pending_reg     <= pending_next;
      pend_rep_reg    <= pend_rep_next;
      for (int i = 0; i < width; i++) cnt_reg[i] <= cnt_next[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg      <= 1'b0;
      index_reg      <= '0;
      repeat_reg     <= 1'b0;
      last_grant_reg <= idx_w'(width - 1);
      dropped_reg    <= 1'b0;
    end else begin
      if (load) begin
        valid_reg      <= 1'b1;
        index_reg      <= grant;
        repeat_reg     <= pend_rep_reg[grant];
        last_grant_reg <= grant;
      end else if (event_ready) begin
        valid_reg      <= 1'b0;
      end
      if (|drop) dropped_reg <= 1'b1;
    end
  end

  assign event_valid   = valid_reg;
  assign event_index   = index_reg;
  assign event_repeat  = repeat_reg;
  assign pending       = pending_reg;
  assign event_dropped = dropped_reg;

endmodule

// File: tb/tb_button_event_scheduler.sv
module tb_button_event_scheduler;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] debounced_signal = 2'b00;
  logic       event_valid;
  logic [0:0] event_index;
  logic       event_repeat;
  logic       event_ready = 1'b0;
  logic [1:0] pending;
  logic       event_dropped;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc[$];
  int acc_idx[$];
  int acc_rep[$];

  button_event_scheduler #(.width(2), .repeat_delay(50), .repeat_period(20)) dut (
    .clk(clk),
    .rst(rst),
    .debounced_signal(debounced_signal),
    .event_valid(event_valid),
    .event_index(event_index),
    .event_repeat(event_repeat),
    .event_ready(event_ready),
    .pending(pending),
    .event_dropped(event_dropped)
  );

  always #5 clk = ~clk;

  // Record every completed handshake with the cycle number of its posedge.
  always @(posedge clk) begin
    if (event_valid && event_ready) begin
      acc_cyc.push_back(cyc);
      acc_idx.push_back(int'(event_index));
      acc_rep.push_back(int'(event_repeat));
      $display("accept cyc=%0d index=%0d repeat=%0d", cyc, event_index, event_repeat);
    end
    cyc <= cyc + 1;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    acc_cyc.delete();
    acc_idx.delete();
    acc_rep.delete();
  endtask

  task automatic test_reset();
    #1;
    checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", event_valid); end
    checks++; if (event_index !== 1'b0) begin errors++; $display("FAIL reset_index: got %b expected 0", event_index); end
    checks++; if (event_repeat !== 1'b0) begin errors++; $display("FAIL reset_repeat: got %b expected 0", event_repeat); end
    checks++; if (pending !== 2'b00) begin errors++; $display("FAIL reset_pending: got %b expected 00", pending); end
    checks++; if (event_dropped !== 1'b0) begin errors++; $display("FAIL reset_dropped: got %b expected 0", event_dropped); end
    step(3);
    rst = 1'b0;
    step(3);
    checks++; if (event_valid !== 1'b0 || pending !== 2'b00) begin errors++; $display("FAIL idle_after_reset: got valid=%b pending=%b expected 0/00", event_valid, pending); end
  endtask

  task automatic test_single_press();
    int rise;
    clear_log();
    event_ready = 1'b1;
    debounced_signal = 2'b01;
    rise = cyc;
    step(1);
    checks++; if (pending !== 2'b01) begin errors++; $display("FAIL single_pending: got %b expected 01", pending); end
    step(9);
    debounced_signal = 2'b00;
    step(6);
    checks++; if (acc_cyc.size() != 1) begin errors++; $display("FAIL single_count: got %0d expected 1", acc_cyc.size()); end
    if (acc_cyc.size() >= 1) begin
      checks++; if (acc_cyc[0] != rise + 2) begin errors++; $display("FAIL single_cycle: got %0d expected %0d", acc_cyc[0], rise + 2); end
      checks++; if (acc_idx[0] != 0 || acc_rep[0] != 0) begin errors++; $display("FAIL single_type: got idx=%0d rep=%0d expected 0/0", acc_idx[0], acc_rep[0]); end
    end
  endtask

  task automatic test_auto_repeat();
    int rise;
    int exp_off[5] = '{2, 52, 72, 92, 112};
    clear_log();
    event_ready = 1'b1;
    debounced_signal = 2'b10;
    rise = cyc;
    step(120);
    debounced_signal = 2'b00;
    step(40);
    checks++; if (acc_cyc.size() != 5) begin errors++; $display("FAIL repeat_count: got %0d expected 5", acc_cyc.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < acc_cyc.size()) begin
        checks++;
        if (acc_cyc[i] != rise + exp_off[i] || acc_idx[i] != 1 || acc_rep[i] != (i == 0 ? 0 : 1)) begin
          errors++;
          $display("FAIL repeat_event%0d: got cyc=%0d idx=%0d rep=%0d expected cyc=%0d idx=1 rep=%0d",
                   i, acc_cyc[i], acc_idx[i], acc_rep[i], rise + exp_off[i], (i == 0 ? 0 : 1));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int rise[2];
    clear_log();
    event_ready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      debounced_signal = 2'b11;
      rise[p] = cyc;
      step(5);
      debounced_signal = 2'b00;
      step(5);
    end
    checks++; if (acc_cyc.size() != 4) begin errors++; $display("FAIL arb_count: got %0d expected 4", acc_cyc.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < acc_cyc.size()) begin
        checks++;
        if (acc_cyc[i] != rise[i/2] + 2 + (i % 2) || acc_idx[i] != (i % 2) || acc_rep[i] != 0) begin
          errors++;
          $display("FAIL arb_event%0d: got cyc=%0d idx=%0d rep=%0d expected cyc=%0d idx=%0d rep=0",
                   i, acc_cyc[i], acc_idx[i], acc_rep[i], rise[i/2] + 2 + (i % 2), i % 2);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int bad;
    clear_log();
    event_ready = 1'b0;
    debounced_signal = 2'b01;
    step(2);
    checks++; if (event_valid !== 1'b1 || event_index !== 1'b0 || event_repeat !== 1'b0) begin errors++; $display("FAIL bp_present: got v=%b i=%b r=%b expected 1/0/0", event_valid, event_index, event_repeat); end
    bad = 0;
    for (int i = 0; i < 28; i++) begin
      if (i == 10) debounced_signal = 2'b00;
      step(1);
      if (event_valid !== 1'b1 || event_index !== 1'b0 || event_repeat !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", bad); end
    checks++; if (pending !== 2'b00) begin errors++; $display("FAIL bp_pending: got %b expected 00", pending); end
    checks++; if (acc_cyc.size() != 0) begin errors++; $display("FAIL bp_no_accept: got %0d expected 0", acc_cyc.size()); end
    event_ready = 1'b1;
    step(1);
    checks++; if (event_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop: got %b expected 0", event_valid); end
    step(3);
    checks++; if (acc_cyc.size() != 1) begin errors++; $display("FAIL bp_accept_count: got %0d expected 1", acc_cyc.size()); end
  endtask

  task automatic test_drop();
    clear_log();
    event_ready = 1'b0;
    checks++; if (event_dropped !== 1'b0) begin errors++; $display("FAIL drop_initial: got %b expected 0", event_dropped); end
    debounced_signal = 2'b01; step(1); debounced_signal = 2'b00; step(2);
    debounced_signal = 2'b01; step(1); debounced_signal = 2'b00; step(1);
    checks++; if (pending !== 2'b01 || event_dropped !== 1'b0) begin errors++; $display("FAIL drop_second: got pending=%b dropped=%b expected 01/0", pending, event_dropped); end
    debounced_signal = 2'b01; step(1); debounced_signal = 2'b00; step(1);
    checks++; if (event_dropped !== 1'b1 || pending !== 2'b01) begin errors++; $display("FAIL drop_third: got dropped=%b pending=%b expected 1/01", event_dropped, pending); end
    event_ready = 1'b1;
    step(6);
    checks++; if (acc_cyc.size() != 2) begin errors++; $display("FAIL drop_accepts: got %0d expected 2", acc_cyc.size()); end
    checks++; if (event_dropped !== 1'b1 || event_valid !== 1'b0) begin errors++; $display("FAIL drop_sticky: got dropped=%b valid=%b expected 1/0", event_dropped, event_valid); end
  endtask

  task automatic test_reset_mid();
    int rise;
    event_ready = 1'b0;
    debounced_signal = 2'b01; step(1);
    debounced_signal = 2'b10; step(1);
    checks++; if (event_valid !== 1'b1 || event_index !== 1'b0 || pending !== 2'b10) begin errors++; $display("FAIL mid_setup: got v=%b i=%b pending=%b expected 1/0/10", event_valid, event_index, pending); end
    rst = 1'b1;
    #1;
    checks++; if (event_valid !== 1'b0 || pending !== 2'b00 || event_dropped !== 1'b0 || event_index !== 1'b0 || event_repeat !== 1'b0) begin
      errors++; $display("FAIL mid_async_clear: got v=%b p=%b d=%b i=%b r=%b expected all 0", event_valid, pending, event_dropped, event_index, event_repeat);
    end
    step(2);
    clear_log();
    event_ready = 1'b1;
    rst = 1'b0;
    rise = cyc;
    step(6);
    checks++; if (acc_cyc.size() != 1) begin errors++; $display("FAIL mid_fresh_count: got %0d expected 1", acc_cyc.size()); end
    if (acc_cyc.size() >= 1) begin
      checks++; if (acc_cyc[0] != rise + 2 || acc_idx[0] != 1 || acc_rep[0] != 0) begin errors++; $display("FAIL mid_fresh_event: got cyc=%0d idx=%0d rep=%0d expected cyc=%0d idx=1 rep=0", acc_cyc[0], acc_idx[0], acc_rep[0], rise + 2); end
    end
    debounced_signal = 2'b00;
    step(2);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_auto_repeat();
    test_back_to_back();
    test_backpressure();
    test_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/button_event_scheduler.md
# button_event_scheduler

Converts the per-button level outputs of the `debouncer` into a single stream of discrete button events for the rest of the lab design. It detects presses, generates auto-repeat events while a button is held, and queues one pending event per channel. It then hands events to a single consumer over a valid/ready handshake, using round-robin arbitration. It sits directly after `debouncer` and shares its `width`.

## Interface
- `width`, 2: number of button channels; must match the upstream debouncer.
- `repeat_delay`, 50: cycles from a press event to the first auto-repeat event; must be ≥1.
- `repeat_period`, 20: cycles between subsequent auto-repeat events; must be ≥1.
- `clk` input 1: single clock; all state updates on posedge.
- `rst` input 1: asynchronous, active-high reset.
- `debounced_signal` input `width`: debounced button levels, synchronous to `clk`.
- `event_valid` output 1: an event is presented.
- `event_index` output max(1,$clog2(`width`)): channel of the presented event.
- `event_repeat` output 1: 0 for a press event, 1 for an auto-repeat event.
- `event_ready` input 1: consumer accepts when `event_valid` && `event_ready` at a posedge.
- `pending` output `width`: per-channel pending-event bits.
- `event_dropped` output 1: sticky flag, set when an event is lost to an already-pending channel.

## Operation
- Edge detect: `prev` is a registered copy of `debounced_signal`. A press on channel i is `debounced_signal[i] & ~prev[i]`.
- Hold counter per channel, width $clog2(max(`repeat_delay`,`repeat_period`)+1):
  - Cleared on a press and whenever the input is low.
  - Counts while the input is high.
  - A repeat tick fires when the count reaches `repeat_delay` for the first repeat and `repeat_period` thereafter. The counter is cleared on each tick.
  - Net effect: ticks at press + `repeat_delay`, then every `repeat_period` cycles, for as long as the input stays high.
- Release (input falls) stops repeats immediately. It does not cancel an event that is already pending or presented.
- Pending: a press or tick sets `pending[i]`, and `pend_rep[i]` records the type (0 = press, 1 = tick).
- Drop rule: if `pending[i]` is already 1 and is not being loaded this cycle, the new event is discarded, `pending[i]`/`pend_rep[i]` stay unchanged, and `event_dropped` is set.
- Output register loads when (`!event_valid` || `event_ready`) and any pending bit is set:
  - The chosen channel's index and type are copied to the outputs, its pending bit is cleared, and `event_valid` is set.
  - If nothing is pending and the handshake completes, `event_valid` clears.
- Round-robin: the search starts at `last_grant`+1 (modulo `width`). `last_grant` updates on every load.
- Same-channel simultaneity: a new event on channel i in the same cycle channel i is loaded sets `pending[i]` again and is not a drop. Set wins over clear.
- While `event_valid` && !`event_ready`, `event_index` and `event_repeat` hold stable.

## Timing
- Reset values: `event_valid`=0, `event_index`=0, `event_repeat`=0, `pending`=0, `event_dropped`=0, `prev`=0, counters=0, `last_grant`=`width`-1 (channel 0 has first priority).
- Reset mid-operation discards all pending and presented events.
- A button already high when reset deasserts produces a press event, because `prev` resets to 0.
- Latency:
  - Input sampled high at posedge t (with `prev`=0) → `pending[i]`=1 after posedge t → `event_valid`=1 after posedge t+1 if the output is free.
  - Back-to-back acceptance sustains one event per cycle.
- Repeat ticks: the first tick is registered `repeat_delay` cycles after the press registers, then every `repeat_period` cycles.
- `event_dropped` clears only on `rst`.

## Test plan
- Single press:
  - Stimulus: ch0 high at cycle 5 for 10 cycles, `event_ready`=1.
  - Response: exactly one event `index`=0, `repeat`=0, `event_valid` high for one cycle 2 cycles after the rise. No repeats (10 < 50).
- Auto-repeat:
  - Stimulus: ch1 held 120 cycles, defaults, `event_ready`=1.
  - Response: press event, then repeat events at +50, +70, +90, +110. Nothing after release.
- Arbitration:
  - Stimulus: ch0 and ch1 rise in the same cycle, `event_ready`=1.
  - Response: ch0 then ch1 on consecutive cycles. A second simultaneous pair is served ch0 then ch1 again (pointer wraps).
- Backpressure:
  - Stimulus: `event_ready`=0 for 30 cycles with a ch0 press.
  - Response: `event_valid`, `index`, and `repeat` stay stable. Release `event_ready` → one accept, then `event_valid` drops.
- Drop:
  - Stimulus: `event_ready`=0, ch0 pressed, released, pressed again twice.
  - Response: the second press becomes pending (the first is presented). The third press sets `event_dropped`=1, which stays 1.
- Reset mid-operation:
  - Stimulus: assert `rst` while `event_valid`=1 and ch1 is pending.
  - Response: all outputs 0 asynchronously. If ch1 is still high after deassert, a fresh press event is produced.
